dbus_axi_bridge: RTL

DBUS_AXI_BRIDGE -- requirements
Module: dbus_axi_bridge

---
 rtl/dbus_pkg.sv | 29 ++
 rtl/dbus_strb_gen.sv | 12 +
 rtl/dbus_axi_bridge.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/dbus_pkg.sv
// Shared types and helpers for the data-bus to AXI3 bridge.
// Optional build macro DBUS_EARLY_WACK_EN: acknowledge stores once AW/W are done.
package dbus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_AR,
    RD_R,
    WR_AW_W,
    WR_B,
    DONE
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_LEN_SINGLE = 4'd0;

  function automatic logic [2:0] size_to_axsize(input logic [1:0] size);
    return {1'b0, size};
  endfunction

  function automatic logic [3:0] size_to_wstrb(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    return 4'b0001 << off;
      2'd1:    return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/dbus_strb_gen.sv
// Byte-lane write strobe from access size and the low address bits.
module dbus_strb_gen
  import dbus_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] wstrb
);

  assign wstrb = size_to_wstrb(size, addr_lo);

endmodule

// File: rtl/dbus_axi_bridge.sv
// Single-outstanding data-bus to AXI3 master bridge (one beat per transfer).
// Build macro DBUS_EARLY_WACK_EN: store data_ok issued after AW/W, B awaited silently.
module dbus_axi_bridge
  import dbus_pkg::*;
#(
  parameter logic [3:0] DBUS_AXI_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  state_t      state, state_nxt;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [1:0]  size_q;
  logic        wr_q, aw_done, w_done;
  logic        accept, aw_hs, w_hs, aw_cmpl, w_cmpl;
  logic        unused_axi;

  assign unused_axi = ^{rid, rresp, rlast, bid, bresp};

  assign accept  = data_req && (state == IDLE) && !rst;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign aw_cmpl = aw_done || aw_hs;
  assign w_cmpl  = w_done || w_hs;

`ifdef DBUS_EARLY_WACK_EN
  // High only in the first WR_B cycle: that is where the early store ack pulses.
  logic wack_first;

  always_ff @(posedge clk) begin
    if (rst) wack_first <= 1'b0;
    else     wack_first <= (state == WR_AW_W) && aw_cmpl && w_cmpl;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      size_q  <= '0;
      wr_q    <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (accept) begin
      addr_q  <= data_addr;
      wdata_q <= data_wdata;
      rdata_q <= '0;
      size_q  <= data_size;
      wr_q    <= data_wr;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if (state == RD_R && rvalid) rdata_q <= rdata;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = data_wr ? WR_AW_W : RD_AR;
      RD_AR:   if (arready) state_nxt = RD_R;
      RD_R:    if (rvalid) state_nxt = DONE;
      WR_AW_W: if (aw_cmpl && w_cmpl) state_nxt = WR_B;
`ifdef DBUS_EARLY_WACK_EN
      WR_B:    if (bvalid) state_nxt = IDLE;
`else
      WR_B:    if (bvalid) state_nxt = DONE;
`endif
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Every handshake output is forced low during reset, even before state settles.
  always_comb begin
    data_addr_ok = accept;
    arvalid      = !rst && (state == RD_AR);
    rready       = !rst && (state == RD_R);
    awvalid      = !rst && (state == WR_AW_W) && !aw_done;
    wvalid       = !rst && (state == WR_AW_W) && !w_done;
    bready       = !rst && (state == WR_B);
    data_data_ok = !rst && (state == DONE);
`ifdef DBUS_EARLY_WACK_EN
    if (!rst && state == WR_B && wack_first) data_data_ok = 1'b1;
`endif
    data_rdata   = (!rst && state == DONE && !wr_q) ? rdata_q : '0;
  end

  assign arid    = DBUS_AXI_ID;
  assign araddr  = addr_q;
  assign arlen   = AXI_LEN_SINGLE;
  assign arsize  = size_to_axsize(size_q);
  assign arburst = AXI_BURST_INCR;

  assign awid    = DBUS_AXI_ID;
  assign awaddr  = addr_q;
  assign awlen   = AXI_LEN_SINGLE;
  assign awsize  = size_to_axsize(size_q);
  assign awburst = AXI_BURST_INCR;

  assign wid     = DBUS_AXI_ID;
  assign wdata   = wdata_q;
  assign wlast   = 1'b1;

  dbus_strb_gen u_strb (
    .size    (size_q),
    .addr_lo (addr_q[1:0]),
    .wstrb   (wstrb)
  );

endmodule
